// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-draining UART transmitter (8 data bits, LSB first, 1 stop bit)
// Optional even parity bit enabled by defining FIFO_UART_TX_PARITY_EN.

module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             fifo_empty_i,
    input  logic [7:0]       fifo_dout_i,
    output logic             fifo_rd_en_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LATCH, S_START, S_DATA, S_PARITY, S_STOP
    } state_e;
    logic parity_q;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LATCH, S_START, S_DATA, S_STOP
    } state_e;
`endif

    state_e             state_q;
    logic [BAUD_W-1:0]  baud_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic               tx_q;
    logic               rd_en_q;
    logic               busy_q;
    logic [CNT_W-1:0]   frame_cnt_q;
    logic               baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    // tx_q is loaded one cycle ahead of each bit so every output stays registered.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            rd_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    if (!fifo_empty_i) begin
                        state_q <= S_READ;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_READ: begin
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    shift_q <= fifo_dout_i;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_q <= ^fifo_dout_i;
`endif
                    tx_q    <= 1'b0;
                    state_q <= S_START;
                end
                S_START: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_last) begin
                        baud_q      <= '0;
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en_o = rd_en_q;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx with a 1-cycle-latency FIFO model

module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int CNT_W = 2;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic             clk;
    logic             srst;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic             fifo_rd_en;
    logic             tx;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .srst_i       (srst),
        .fifo_empty_i (fifo_empty),
        .fifo_dout_i  (fifo_dout),
        .fifo_rd_en_o (fifo_rd_en),
        .tx_o         (tx),
        .busy_o       (busy),
        .frame_cnt_o  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:63];
    int         wr_ptr;
    int         rd_ptr;
    logic [7:0] exp_q [$];
    int         exp_cnt;
    int         rd_pulses;
    int         checks;
    int         errors;

    always_comb fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_dout <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (fifo_rd_en === 1'b1) rd_pulses <= rd_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(b);
    endtask

    // Counts tx-high cycles (including the current one) until a start bit appears.
    task automatic wait_start(output int n);
        n = 0;
        while (tx !== 1'b0 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Entered on the first start-bit cycle; leaves on the first idle cycle after stop.
    task automatic recv_frame(input string tag);
        logic [10:0] obs;
        logic [10:0] expv;
        logic [7:0]  b;
        int          unstable;
        obs      = '1;
        unstable = 0;
        for (int i = 0; i < NB * CPB; i++) begin
            if (i > 0) @(negedge clk);
            if (i % CPB == 0) obs[i / CPB] = tx;
            else if (tx !== obs[i / CPB]) unstable++;
            if (busy !== 1'b1) unstable++;
        end
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_pending"}, exp_q.size(), 1);
        end else begin
            b = exp_q.pop_front();
            expv      = '1;
            expv[0]   = 1'b0;
            expv[8:1] = b;
`ifdef FIFO_UART_TX_PARITY_EN
            expv[9]   = ^b;
`endif
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            check_eq({tag, "_bits"}, obs, expv);
            check_eq({tag, "_stable"}, unstable, 0);
            check_eq({tag, "_frame_cnt"}, frame_cnt, exp_cnt);
            check_eq({tag, "_busy_low"}, busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int viol;
        logic [7:0] dropped;
        checks = 0; errors = 0; wr_ptr = 0; rd_ptr = 0;
        exp_cnt = 0; rd_pulses = 0; fifo_dout = 8'h00;
        srst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd_en", fifo_rd_en, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        srst = 1'b0;

        viol = 0;
        rd_pulses = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) viol++;
        end
        check_eq("empty_quiet", viol, 0);
        check_eq("empty_rd", rd_pulses, 0);

        rd_pulses = 0;
        push(8'hA5);
        wait_start(n);
        check_eq("single_lat", n, 3);
        recv_frame("single");
        check_eq("single_rd", rd_pulses, 1);

        rd_pulses = 0;
        push(8'h00); push(8'hFF); push(8'h3C);
        wait_start(n);
        check_eq("b2b_lat", n, 3);
        recv_frame("b2b0");
        wait_start(n);
        check_eq("b2b_gap1", n, 3);
        recv_frame("b2b1");
        wait_start(n);
        check_eq("b2b_gap2", n, 3);
        recv_frame("b2b2");
        repeat (10) @(negedge clk);
        check_eq("b2b_rd", rd_pulses, 3);

        push(8'h5A); push(8'h81);
        wait_start(n);
        repeat (17) @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        check_eq("midrst_tx", tx, 1);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_frame_cnt", frame_cnt, 0);
        srst = 1'b0;
        exp_cnt = 0;
        dropped = exp_q.pop_front();
        rd_pulses = 0;
        wait_start(n);
        check_eq("midrst_relat", n, 3);
        recv_frame("midrst");
        check_eq("midrst_rd", rd_pulses, 1);

        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        exp_cnt = 0;
        check_eq("wrap_rst_cnt", frame_cnt, 0);
        push(8'h07);
        for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
        for (int i = 0; i < 5; i++) begin
            wait_start(n);
            check_eq("wrap_lat", n, (i == 0) ? 3 : 3);
            recv_frame("wrap");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
